// File: rtl/sha256_hash_responder.sv
`default_nettype none
// ============================================================================
// Module   : sha256_hash_responder
// Purpose  : Responder for tweakable-hash requests. Pads 768/1024-bit
//            messages for SHA-256, sequences up to three 512-bit blocks into
//            a single-block compression core and keeps the first-block
//            midstate so requests sharing block 0 can skip it.
// Revision : 1.0 - initial release
// ============================================================================
module sha256_hash_responder #(
  parameter int                    DIGEST_LEN = 256,
  parameter logic [DIGEST_LEN-1:0] IV         =
    256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  hash_start,
  input  logic [1023:0]         hash_data_in,
  input  logic                  message_length,
  input  logic                  continue_intermediate,
  output logic [DIGEST_LEN-1:0] hash_data_out,
  output logic                  hash_done,
  output logic                  busy,
  output logic                  comp_start,
  output logic [511:0]          comp_block,
  output logic [DIGEST_LEN-1:0] comp_state_in,
  input  logic                  comp_done,
  input  logic [DIGEST_LEN-1:0] comp_state_out
);

  localparam logic [2:0] c_IDLE = 3'd0;
  localparam logic [2:0] c_B0   = 3'd1;
  localparam logic [2:0] c_B1   = 3'd2;
  localparam logic [2:0] c_B2   = 3'd3;
  localparam logic [2:0] c_FIN  = 3'd4;

  // Padding-only final block of a 1024-bit message.
  localparam logic [511:0] c_BLOCK2 = {8'h80, 440'd0, 64'd1024};

  logic [2:0]            state_q, state_d;
  logic [1023:0]         data_q, data_d;
  logic                  len_q, len_d;
  logic [DIGEST_LEN-1:0] midstate_q, midstate_d;
  logic                  mid_valid_q, mid_valid_d;
  logic                  comp_start_q, comp_start_d;
  logic [511:0]          comp_block_q, comp_block_d;
  logic [DIGEST_LEN-1:0] comp_state_in_q, comp_state_in_d;
  logic [DIGEST_LEN-1:0] hash_data_out_q, hash_data_out_d;
  logic                  hash_done_q, hash_done_d;

  logic w_accept;
  logic w_eff_cont;

  // Second block: either the raw low half or the 768-bit message tail with padding.
  function automatic logic [511:0] f_block1(input logic [1023:0] d, input logic len);
    if (len) begin
      return d[511:0];
    end
    return {d[511:256], 8'h80, 184'd0, 64'd768};
  endfunction

  // A request is taken when idle, or in the done cycle to allow chained requests.
  assign w_accept   = hash_start && ((state_q == c_IDLE) || (state_q == c_FIN));
  // The stored midstate is only trusted once a block 0 has completed since reset.
  assign w_eff_cont = continue_intermediate & mid_valid_q;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= c_IDLE;
      data_q          <= '0;
      len_q           <= 1'b0;
      midstate_q      <= '0;
      mid_valid_q     <= 1'b0;
      comp_start_q    <= 1'b0;
      comp_block_q    <= '0;
      comp_state_in_q <= '0;
      hash_data_out_q <= '0;
      hash_done_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      data_q          <= data_d;
      len_q           <= len_d;
      midstate_q      <= midstate_d;
      mid_valid_q     <= mid_valid_d;
      comp_start_q    <= comp_start_d;
      comp_block_q    <= comp_block_d;
      comp_state_in_q <= comp_state_in_d;
      hash_data_out_q <= hash_data_out_d;
      hash_done_q     <= hash_done_d;
    end
  end

  // Next-state logic: walk the blocks, advancing on each core completion.
  always_comb begin
    state_d = state_q;
    case (state_q)
      c_IDLE:  if (hash_start) state_d = w_eff_cont ? c_B1 : c_B0;
      c_B0:    if (comp_done) state_d = c_B1;
      c_B1:    if (comp_done) state_d = len_q ? c_B2 : c_FIN;
      c_B2:    if (comp_done) state_d = c_FIN;
      c_FIN:   state_d = hash_start ? (w_eff_cont ? c_B1 : c_B0) : c_IDLE;
      default: state_d = c_IDLE;
    endcase
  end

  // Output/datapath logic: issue core requests and capture results.
  always_comb begin
    data_d          = data_q;
    len_d           = len_q;
    midstate_d      = midstate_q;
    mid_valid_d     = mid_valid_q;
    comp_start_d    = 1'b0;
    comp_block_d    = comp_block_q;
    comp_state_in_d = comp_state_in_q;
    hash_data_out_d = hash_data_out_q;
    hash_done_d     = 1'b0;

    if (w_accept) begin
      data_d       = hash_data_in;
      len_d        = message_length;
      comp_start_d = 1'b1;
      if (w_eff_cont) begin
        comp_block_d    = f_block1(hash_data_in, message_length);
        comp_state_in_d = midstate_q;
      end else begin
        comp_block_d    = hash_data_in[1023:512];
        comp_state_in_d = IV;
      end
    end

    case (state_q)
      c_B0: begin
        if (comp_done) begin
          midstate_d      = comp_state_out;
          mid_valid_d     = 1'b1;
          comp_start_d    = 1'b1;
          comp_block_d    = f_block1(data_q, len_q);
          comp_state_in_d = comp_state_out;
        end
      end
      c_B1: begin
        if (comp_done) begin
          if (len_q) begin
            comp_start_d    = 1'b1;
            comp_block_d    = c_BLOCK2;
            comp_state_in_d = comp_state_out;
          end else begin
            hash_data_out_d = comp_state_out;
            hash_done_d     = 1'b1;
          end
        end
      end
      c_B2: begin
        if (comp_done) begin
          hash_data_out_d = comp_state_out;
          hash_done_d     = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign busy          = (state_q != c_IDLE);
  assign hash_done     = hash_done_q;
  assign hash_data_out = hash_data_out_q;
  assign comp_start    = comp_start_q;
  assign comp_block    = comp_block_q;
  assign comp_state_in = comp_state_in_q;

endmodule
`default_nettype wire

// File: tb/tb_sha256_hash_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_sha256_hash_responder
// Purpose  : Directed bench for sha256_hash_responder with a behavioural
//            SHA-256 compression core attached to the core-side ports.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sha256_hash_responder;

  localparam logic [255:0] IV =
    256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam int LAT = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          hash_start = 1'b0;
  logic [1023:0] hash_data_in = '0;
  logic          message_length = 1'b0;
  logic          continue_intermediate = 1'b0;
  logic [255:0]  hash_data_out;
  logic          hash_done;
  logic          busy;
  logic          comp_start;
  logic [511:0]  comp_block;
  logic [255:0]  comp_state_in;
  logic          comp_done = 1'b0;
  logic [255:0]  comp_state_out = '0;

  always #5 clk = ~clk;

  sha256_hash_responder dut (
    .clk                   (clk),
    .reset                 (reset),
    .hash_start            (hash_start),
    .hash_data_in          (hash_data_in),
    .message_length        (message_length),
    .continue_intermediate (continue_intermediate),
    .hash_data_out         (hash_data_out),
    .hash_done             (hash_done),
    .busy                  (busy),
    .comp_start            (comp_start),
    .comp_block            (comp_block),
    .comp_state_in         (comp_state_in),
    .comp_done             (comp_done),
    .comp_state_out        (comp_state_out)
  );

  // ---------------- SHA-256 compression reference ----------------
  logic [31:0] K [64];
  initial K = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] sha_comp(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    for (int t = 0; t < 16; t++) w[t] = blk[511-32*t -: 32];
    for (int t = 16; t < 64; t++)
      w[t] = (ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
           + (ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
    {a, b, c, d, e, f, g, h} = hin;
    for (int t = 0; t < 64; t++) begin
      t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + K[t] + w[t];
      t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {hin[255:224] + a, hin[223:192] + b, hin[191:160] + c, hin[159:128] + d,
            hin[127:96] + e, hin[95:64] + f, hin[63:32] + g, hin[31:0] + h};
  endfunction

  // ---------------- behavioural core + observers (negedge) ----------------
  int           nstarts = 0;
  int           ndone = 0;
  int           stab_err = 0;
  logic [511:0] st_blk [8];
  logic [255:0] st_cv [8];
  logic         pend = 1'b0;
  logic         aborted = 1'b0;
  int           cnt = 0;
  logic [511:0] cap_blk = '0;
  logic [255:0] cap_cv = '0;

  always @(negedge clk) begin
    comp_done = 1'b0;
    if (hash_done) ndone++;
    if (reset) aborted = 1'b1;
    if (pend) begin
      if (!aborted && (comp_block !== cap_blk || comp_state_in !== cap_cv)) stab_err++;
      cnt--;
      if (cnt == 0) begin
        comp_done      = 1'b1;
        comp_state_out = sha_comp(cap_cv, cap_blk);
        pend           = 1'b0;
      end
    end
    if (comp_start) begin
      if (nstarts < 8) begin
        st_blk[nstarts] = comp_block;
        st_cv[nstarts]  = comp_state_in;
      end
      nstarts++;
      cap_blk = comp_block;
      cap_cv  = comp_state_in;
      cnt     = LAT;
      pend    = 1'b1;
      aborted = 1'b0;
    end
  end

  // ---------------- checking helpers ----------------
  int n_assert = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse(input logic [1023:0] d, input logic len, input logic cont);
    hash_data_in          = d;
    message_length        = len;
    continue_intermediate = cont;
    hash_start            = 1'b1;
    tick();
    hash_start            = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (hash_done) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    chk(tag, ok, 1'b1);
  endtask

  task automatic wait_starts(input int n, input string tag);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (nstarts >= n) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    chk(tag, ok, 1'b1);
  endtask

  // ---------------- directed sequence ----------------
  logic [1023:0] d1, d2;
  logic [511:0]  b0, b1, b1b, b2;
  logic [255:0]  mid, dig, dig2, mz, dz;
  int            nd0;

  initial begin
    d1   = {256'h3, {32{8'hA5}}, 256'h1_0000_0000, 256'h0};
    d2   = {256'h3, {32{8'hA5}}, 256'h1_0000_0001, 256'h0};
    b0   = d1[1023:512];
    b1   = {d1[511:256], 8'h80, 184'd0, 64'h300};
    b1b  = {d2[511:256], 8'h80, 184'd0, 64'h300};
    b2   = {8'h80, 440'd0, 64'h400};
    mid  = sha_comp(IV, b0);
    dig  = sha_comp(mid, b1);
    dig2 = sha_comp(mid, b1b);
    mz   = sha_comp(IV, 512'h0);
    dz   = sha_comp(sha_comp(mz, 512'h0), b2);

    // Reference sanity: SHA-256("abc").
    chk("model_abc", sha_comp(IV, {32'h61626380, 416'd0, 64'h18}),
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad);

    // Reset state
    tick(); tick(); tick();
    reset = 1'b0;
    tick();
    chk("rst_ctrl", {hash_done, busy, comp_start}, 3'b000);
    chk("rst_out", hash_data_out, 256'h0);
    chk("rst_blk", comp_block, 512'h0);
    chk("rst_cv", comp_state_in, 256'h0);
    chk("rst_midv", dut.mid_valid_q, 1'b0);
    chk("rst_mid", dut.midstate_q, 256'h0);

    // 768-bit message, no continuation
    nstarts = 0;
    pulse(d1, 1'b0, 1'b0);
    chk("t1_busy", busy, 1'b1);
    wait_done("t1_timeout");
    chk("t1_nstarts", nstarts, 2);
    chk("t1_blk0", st_blk[0], b0);
    chk("t1_cv0", st_cv[0], IV);
    chk("t1_blk1", st_blk[1], b1);
    chk("t1_cv1", st_cv[1], mid);
    chk("t1_digest", hash_data_out, dig);
    chk("t1_mid", dut.midstate_q, mid);
    chk("t1_midv", dut.mid_valid_q, 1'b1);
    tick();
    chk("t1_after", {hash_done, busy}, 2'b00);
    chk("t1_digest_hold", hash_data_out, dig);
    chk("t1_stable", stab_err, 0);

    // Same key, continue from stored midstate
    nstarts = 0;
    pulse(d2, 1'b0, 1'b1);
    wait_done("t2_timeout");
    chk("t2_nstarts", nstarts, 1);
    chk("t2_cv0", st_cv[0], mid);
    chk("t2_blk0", st_blk[0], b1b);
    chk("t2_digest", hash_data_out, dig2);
    tick();

    // Continue right after reset falls back to full hash
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    nstarts = 0;
    pulse(d1, 1'b0, 1'b1);
    wait_done("t3_timeout");
    chk("t3_nstarts", nstarts, 2);
    chk("t3_cv0", st_cv[0], IV);
    chk("t3_blk0", st_blk[0], b0);
    chk("t3_midv", dut.mid_valid_q, 1'b1);
    chk("t3_digest", hash_data_out, dig);
    tick();

    // 1024-bit all-zero message
    nstarts = 0;
    pulse(1024'h0, 1'b1, 1'b0);
    wait_done("t4_timeout");
    chk("t4_nstarts", nstarts, 3);
    chk("t4_blk2", st_blk[2], b2);
    chk("t4_cv2", st_cv[2], sha_comp(mz, 512'h0));
    chk("t4_digest", hash_data_out, dz);
    chk("t4_mid", dut.midstate_q, mz);
    chk("t4_stable", stab_err, 0);
    tick();

    // Spurious starts during B1, then a chained start in the done cycle
    nstarts = 0;
    nd0 = ndone;
    pulse(d1, 1'b0, 1'b0);
    wait_starts(2, "t5_b1_timeout");
    hash_data_in   = {1024{1'b1}};
    message_length = 1'b1;
    hash_start     = 1'b1;
    tick();
    tick();
    hash_start = 1'b0;
    chk("t5_busy", busy, 1'b1);
    wait_done("t5_timeout");
    chk("t5_digest", hash_data_out, dig);
    chk("t5_ndone1", ndone - nd0, 1);
    chk("t5_nstarts", nstarts, 2);
    nstarts = 0;
    pulse(d2, 1'b0, 1'b1);
    chk("t5_chain_busy", busy, 1'b1);
    wait_done("t5_chain_timeout");
    chk("t5_chain_nstarts", nstarts, 1);
    chk("t5_chain_digest", hash_data_out, dig2);
    chk("t5_ndone2", ndone - nd0, 2);
    tick();

    // Reset between comp_start and comp_done
    nstarts = 0;
    nd0 = ndone;
    pulse(d1, 1'b0, 1'b0);
    wait_starts(1, "t6_start_timeout");
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_ctrl", {hash_done, busy, comp_start}, 3'b000);
    chk("t6_out", hash_data_out, 256'h0);
    chk("t6_blk", comp_block, 512'h0);
    chk("t6_state", dut.state_q, 3'd0);
    chk("t6_midv", dut.mid_valid_q, 1'b0);
    for (int i = 0; i < 10; i++) tick();
    chk("t6_no_done", ndone - nd0, 0);
    chk("t6_idle", {busy, comp_start}, 2'b00);
    chk("t6_out_late", hash_data_out, 256'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
